// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the RV32I memory-access stage.
//   - access size encodings (SZ_*)
//   - LSU state enum (lsu_state_t)
//   - byte-enable constants and helpers for lane placement and alignment
package rv32_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // Illegal size or an address not naturally aligned to the access size.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = BE_WORD;
    case (size)
      SZ_BYTE: be = BE_BYTE0 << lo;
      SZ_HALF: be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Replicate the significant store bits across all lanes so the byte
  // enables alone select what the memory writes.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// rv32_load_align: combinational load-data alignment.
// Shifts the addressed lane down to bit 0 and sign/zero-extends byte and
// half accesses; word accesses pass through unchanged.
// Ports:
//   rdata   in  32  raw read word from the bus
//   addr_lo in   2  byte offset within the word
//   size    in   2  access size (SZ_*)
//   unsig   in   1  1 = zero-extend, 0 = sign-extend
//   result  out 32  extended load value
import rv32_pkg::*;

module rv32_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsig,
  output logic [31:0] result
);

  logic [31:0] lane;

  always_comb begin
    lane   = rdata >> {addr_lo, 3'b000};
    result = rdata;
    case (size)
      SZ_BYTE: result = unsig ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: result = unsig ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/rv32_lsu_unit.sv
// rv32_lsu_unit: RV32I memory-access stage.
// Runs one data-memory transaction per operation over a req/ready bus,
// stalling the upstream pipeline registers while it is outstanding.
// Ports:
//   clk_in, rst_in (async active-low)
//   mem_req_in/mem_we_in/addr_in/wdata_in/size_in/load_unsig_in : operation
//   dmem_req_out/we/addr/be/wdata, dmem_ready_in, dmem_rdata_in : data bus
//   stall_out : hold upstream; done_out/err_out/rdata_out : completion
// Parameter TIMEOUT_CYCLES: max BUSY cycles without ready (0 = no timeout).
import rv32_pkg::*;

module rv32_lsu_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  size_in,
  input  logic        load_unsig_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [3:0]  dmem_be_out,
  output logic [31:0] dmem_wdata_out,
  input  logic        dmem_ready_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        stall_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        err_out
);

  // state | meaning
  // IDLE  | waiting for mem_req_in; bad accesses go straight to DONE
  // BUSY  | bus request held until dmem_ready_in or timeout
  // DONE  | one-cycle completion pulse, pipeline advances

  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter loaded with N-1 so terminal count 0 lands on the Nth BUSY cycle.
  localparam logic [TW-1:0] TMO_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t  state_q, state_d;
  logic        we_q;
  logic [29:0] waddr_q;
  logic [1:0]  lo_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsig_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [TW-1:0] tmo_q;

  logic        accept, reject, tmo_hit, capture;
  logic [31:0] load_val;

  rv32_load_align u_align (
    .rdata   (dmem_rdata_in),
    .addr_lo (lo_q),
    .size    (size_q),
    .unsig   (unsig_q),
    .result  (load_val)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    tmo_hit = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_in) begin
          if (access_bad(size_in, addr_in[1:0])) begin
            reject  = 1'b1;
            state_d = ST_DONE;
          end else begin
            accept  = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // Ready wins over a coincident timeout.
        if (dmem_ready_in) begin
          capture = ~we_q;
          state_d = ST_DONE;
        end else if (TMO_EN && (tmo_q == '0)) begin
          tmo_hit = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      lo_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      unsig_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= mem_we_in;
        waddr_q <= addr_in[31:2];
        lo_q    <= addr_in[1:0];
        be_q    <= byte_enables(size_in, addr_in[1:0]);
        wdata_q <= store_lanes(size_in, wdata_in);
        size_q  <= size_in;
        unsig_q <= load_unsig_in;
        err_q   <= 1'b0;
        tmo_q   <= TMO_LOAD;
      end else if (state_q == ST_BUSY && tmo_q != '0) begin
        tmo_q <= tmo_q - 1'b1;
      end
      if (reject || tmo_hit) begin
        err_q <= 1'b1;
      end
      if (capture) begin
        rdata_q <= load_val;
      end
    end
  end

  assign dmem_req_out   = (state_q == ST_BUSY);
  assign dmem_we_out    = (state_q == ST_BUSY) & we_q;
  assign dmem_addr_out  = {waddr_q, 2'b00};
  assign dmem_be_out    = be_q;
  assign dmem_wdata_out = wdata_q;
  assign stall_out      = ((state_q == ST_IDLE) & mem_req_in) | (state_q == ST_BUSY);
  assign done_out       = (state_q == ST_DONE);
  assign err_out        = (state_q == ST_DONE) & err_q;
  assign rdata_out      = rdata_q;

endmodule

// File: tb/tb_rv32_lsu_unit.sv
module tb_rv32_lsu_unit;

  localparam int TMO = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        mem_req_in = 1'b0;
  logic        mem_we_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [1:0]  size_in = '0;
  logic        load_unsig_in = 1'b0;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_ready_in = 1'b0;
  logic [31:0] dmem_rdata_in = '0;
  logic        stall_out, done_out, err_out;
  logic [31:0] rdata_out;

  rv32_lsu_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .size_in(size_in), .load_unsig_in(load_unsig_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_be_out(dmem_be_out),
    .dmem_wdata_out(dmem_wdata_out), .dmem_ready_in(dmem_ready_in),
    .dmem_rdata_in(dmem_rdata_in), .stall_out(stall_out), .done_out(done_out),
    .rdata_out(rdata_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in && done_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_err"},   {31'd0, err_out}, {31'd0, e.err});
        check({e.name, "_rdata"}, rdata_out, e.rdata);
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  // kind: 0 normal bus transaction, 1 rejected (no bus), 2 timeout
  task automatic do_op(input string nm, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic un,
                       input logic [31:0] rd, input int kind, input int waits,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic eerr, input logic [31:0] erd, input int lat);
    exp_t e;
    int n;
    @(posedge clk_in); #1;
    mem_req_in = 1'b1; mem_we_in = we; addr_in = a; wdata_in = wd;
    size_in = sz; load_unsig_in = un;
    e.name = nm; e.err = eerr; e.rdata = erd; e.cyc = cyc + lat;
    exp_q.push_back(e);
    @(negedge clk_in);
    check({nm, "_stall_req"}, {31'd0, stall_out}, 32'd1);
    @(posedge clk_in); #1;
    mem_req_in = 1'b0;
    if (kind == 1) begin
      @(negedge clk_in);
      check({nm, "_no_req"}, {31'd0, dmem_req_out}, 32'd0);
    end else begin
      n = (kind == 2) ? TMO : waits + 1;
      for (int i = 0; i < n; i++) begin
        dmem_ready_in = (kind == 0) && (i == waits);
        dmem_rdata_in = rd;
        @(negedge clk_in);
        check({nm, "_req"},   {31'd0, dmem_req_out}, 32'd1);
        check({nm, "_we"},    {31'd0, dmem_we_out}, {31'd0, we});
        check({nm, "_stall"}, {31'd0, stall_out}, 32'd1);
        check({nm, "_addr"},  dmem_addr_out, {a[31:2], 2'b00});
        check({nm, "_be"},    {28'd0, dmem_be_out}, {28'd0, ebe});
        if (we) check({nm, "_wdata"}, dmem_wdata_out, ewd);
        @(posedge clk_in); #1;
        dmem_ready_in = 1'b0;
      end
    end
    @(negedge clk_in);
    check({nm, "_done_stall"}, {31'd0, stall_out}, 32'd0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check({nm, "_idle_req"},  {31'd0, dmem_req_out}, 32'd0);
    check({nm, "_idle_done"}, {31'd0, done_out}, 32'd0);
  endtask

  initial begin
    int reqs;
    logic [5:0] stall_pat;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_req",   {31'd0, dmem_req_out}, 32'd0);
    check("rst_we",    {31'd0, dmem_we_out}, 32'd0);
    check("rst_done",  {31'd0, done_out}, 32'd0);
    check("rst_err",   {31'd0, err_out}, 32'd0);
    check("rst_addr",  dmem_addr_out, 32'd0);
    check("rst_be",    {28'd0, dmem_be_out}, 32'd0);
    check("rst_wdata", dmem_wdata_out, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    rst_in = 1'b1;

    //    name      we    addr          wdata         sz     un    rdata        kind w  be       wdata_exp     err   rdata_exp     lat
    do_op("lb",     1'b0, 32'h0000_1003, 32'h0,        2'b00, 1'b0, 32'h80FF_1234, 0, 0, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80, 2);
    do_op("lbu",    1'b0, 32'h0000_1003, 32'h0,        2'b00, 1'b1, 32'h80FF_1234, 0, 0, 4'b1000, 32'h0,        1'b0, 32'h0000_0080, 2);
    do_op("sh",     1'b1, 32'h0000_2002, 32'h0000_ABCD, 2'b01, 1'b0, 32'h0,        0, 3, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0000_0080, 5);
    do_op("lw_mis", 1'b0, 32'h0000_0006, 32'h0,        2'b10, 1'b0, 32'h0,         1, 0, 4'b0000, 32'h0,        1'b1, 32'h0000_0080, 1);
    do_op("tmo",    1'b0, 32'h0000_0040, 32'h0,        2'b10, 1'b0, 32'h0,         2, 0, 4'b1111, 32'h0,        1'b1, 32'h0000_0080, 1 + TMO);
    do_op("lh",     1'b0, 32'h0000_2002, 32'h0,        2'b01, 1'b0, 32'h8001_7FFF, 0, 1, 4'b1100, 32'h0,        1'b0, 32'hFFFF_8001, 3);
    do_op("lhu",    1'b0, 32'h0000_0000, 32'h0,        2'b01, 1'b1, 32'h1234_F00D, 0, 0, 4'b0011, 32'h0,        1'b0, 32'h0000_F00D, 2);
    do_op("lbu5",   1'b0, 32'h0000_0005, 32'h0,        2'b00, 1'b1, 32'hAABB_CCDD, 0, 0, 4'b0010, 32'h0,        1'b0, 32'h0000_00CC, 2);
    do_op("sb",     1'b1, 32'h0000_0007, 32'h1234_5678, 2'b00, 1'b0, 32'h0,        0, 0, 4'b1000, 32'h7878_7878, 1'b0, 32'h0000_00CC, 2);
    do_op("sw",     1'b1, 32'h0000_0008, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,        0, 2, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0000_00CC, 4);
    do_op("sz_ill", 1'b0, 32'h0000_0000, 32'h0,        2'b11, 1'b0, 32'h0,         1, 0, 4'b0000, 32'h0,        1'b1, 32'h0000_00CC, 1);
    do_op("sh_mis", 1'b1, 32'h0000_0003, 32'h0000_1111, 2'b01, 1'b0, 32'h0,        1, 0, 4'b0000, 32'h0,        1'b1, 32'h0000_00CC, 1);

    // Reset in the middle of a bus transaction.
    @(posedge clk_in); #1;
    mem_req_in = 1'b1; mem_we_in = 1'b0; addr_in = 32'h30; size_in = 2'b10;
    @(posedge clk_in); #1;
    mem_req_in = 1'b0;
    @(negedge clk_in);
    check("mid_busy_req", {31'd0, dmem_req_out}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("rst_async_req",   {31'd0, dmem_req_out}, 32'd0);
    check("rst_async_done",  {31'd0, done_out}, 32'd0);
    check("rst_async_stall", {31'd0, stall_out}, 32'd0);
    check("rst_async_rdata", rdata_out, 32'd0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("rst_hold_req", {31'd0, dmem_req_out}, 32'd0);
    rst_in = 1'b1;
    do_op("lw_post", 1'b0, 32'h0000_0010, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);

    // mem_req_in held high across two loads with a zero-wait bus.
    @(posedge clk_in); #1;
    mem_req_in = 1'b1; mem_we_in = 1'b0; addr_in = 32'h20; size_in = 2'b10;
    dmem_ready_in = 1'b1; dmem_rdata_in = 32'h1234_5678;
    begin
      exp_t e;
      e.name = "b2b_a"; e.err = 1'b0; e.rdata = 32'h1234_5678; e.cyc = cyc + 2;
      exp_q.push_back(e);
      e.name = "b2b_b"; e.cyc = cyc + 5;
      exp_q.push_back(e);
    end
    stall_pat = 6'b011011; // bit i = stall expected in cycle i
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      check("b2b_stall", {31'd0, stall_out}, {31'd0, stall_pat[i]});
      if (dmem_req_out) reqs++;
      @(posedge clk_in); #1;
      if (i == 4) mem_req_in = 1'b0;
    end
    dmem_ready_in = 1'b0;
    check("b2b_req_count", reqs, 32'd2);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("final_idle_req", {31'd0, dmem_req_out}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv32_lsu_unit.md
# rv32_lsu_unit

Memory-access stage of the RV32I pipeline: consumes the registered execute-stage outputs (effective address, store data, access size, unsigned-load flag) and runs one data-memory transaction per operation over a req/ready bus. It generates byte enables and lane-replicated store data, aligns and sign/zero-extends load data, detects misalignment and bus timeout, and stalls the upstream pipeline registers while a transaction is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, max BUSY cycles waiting for dmem_ready_in; 0 disables the timeout.

Ports:
- clk_in  input  1  clock; all state changes on rising edge
- rst_in  input  1  asynchronous, active-low reset
- mem_req_in  input  1  memory operation present in the stage (level)
- mem_we_in  input  1  1 = store, 0 = load
- addr_in  input  32  effective byte address
- wdata_in  input  32  store data (low bits significant for byte/half)
- size_in  input  2  00 byte, 01 half, 10 word, 11 illegal
- load_unsig_in  input  1  1 = zero-extend load, 0 = sign-extend
- dmem_req_out  output  1  bus request, held until accepted
- dmem_we_out  output  1  bus write enable
- dmem_addr_out  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be_out  output  4  byte enables
- dmem_wdata_out  output  32  lane-replicated store data
- dmem_ready_in  input  1  accept; for loads dmem_rdata_in valid same cycle
- dmem_rdata_in  input  32  read data word
- stall_out  output  1  hold upstream pipeline registers
- done_out  output  1  one-cycle completion pulse
- rdata_out  output  32  extended load result, valid when done_out and load
- err_out  output  1  with done_out: misaligned/illegal size or timeout

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, mem_req_in=1, legal and aligned: latch we/addr/be/wdata/size/unsig; -> BUSY.
- IDLE, mem_req_in=1, misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: no bus request; set err; -> DONE.
- BUSY: dmem_req_out=1, all bus outputs stable. dmem_ready_in=1: capture extended load data (loads) -> DONE. Timeout counter reaches TIMEOUT_CYCLES without ready: drop request, set err -> DONE.
- DONE: done_out=1, err_out per latched flag; unconditionally -> IDLE. rdata_out held until next completion.
- Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111. Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata. Loads drive be per same rule.
- Load extraction: lane = dmem_rdata_in >> (8*addr[1:0]); byte/half extended to 32 bits per load_unsig; word passes through.
- stall_out = (IDLE & mem_req_in) | BUSY. Low in DONE so the pipeline advances exactly once per operation.
- Stores return rdata_out unchanged; err on a store suppresses the write entirely.

## Timing
- Reset (async, rst_in=0): state IDLE; dmem_req_out, dmem_we_out, done_out, err_out = 0; dmem_addr_out, dmem_be_out, dmem_wdata_out, rdata_out = 0; timeout counter = 0. Reset mid-BUSY drops the request immediately, with no done pulse.
- Zero-wait bus: request cycle 0 (IDLE), dmem_req_out=1 cycle 1 with ready=1, done_out cycle 2. Latency = 2 + wait cycles.
- Misaligned/illegal: done_out and err_out in cycle 1; dmem_req_out never asserted.
- Timeout: with TIMEOUT_CYCLES=N, dmem_req_out is high for exactly N cycles, and done_out/err_out follow in the next cycle.
- mem_req_in is ignored in BUSY and DONE. A new op is taken only in IDLE, so back-to-back ops have a period of at least 3 cycles.
- dmem_ready_in outside BUSY is ignored.

## Structure
- Shared package rv32_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), lsu_state_t enum, byte-enable constants.
- Sub-module rv32_load_align: combinational lane select plus sign/zero extension (inputs rdata, addr[1:0], size, unsig), reusable by the CSR/debug read path.

## Test plan
- Load byte signed: addr 0x1003, rdata 0x80FF_1234, ready immediate -> be 4'b1000, done cycle 2, rdata_out 0xFFFF_FF80; with unsig=1 -> 0x0000_0080.
- Store half: addr 0x2002, wdata 0x0000_ABCD, ready after 3 waits -> be 4'b1100, wdata_out 0xABCD_ABCD, bus outputs stable 4 cycles, stall_out high until done.
- Misaligned word load at 0x0000_0006 -> no dmem_req_out, done_out=err_out=1 in cycle 1.
- Timeout with TIMEOUT_CYCLES=4, ready held 0 -> dmem_req_out high 4 cycles, then done_out=err_out=1, state IDLE.
- Reset asserted mid-BUSY -> dmem_req_out, done_out drop asynchronously. After release, a word load at 0x10 with rdata 0xDEAD_BEEF -> rdata_out 0xDEAD_BEEF.
- mem_req_in held high continuously for two loads -> exactly two transactions, done pulses 3 cycles apart, stall_out low only in DONE cycles.
